conversor_bcd_resultado: RTL

Downstream stage of the 4x4 multiplication subsystem. Captures the 8-bit unsigned product when the multiplier flags it ready. Converts it to three packed BCD digits with a sequential shift-and-add-3 (double-dabble) engine, one iteration per clock. Holds the digits for the seven-segment display driver and pulses a valid flag when each conversion completes.

---
 rtl/conversor_bcd_resultado_pkg.sv | 25 ++
 rtl/conversor_bcd_resultado_celda_suma3.sv | 20 ++
 rtl/conversor_bcd_resultado.sv | 124 ++++++++++++
 3 files changed

// File: rtl/conversor_bcd_resultado_pkg.sv
// Shared definitions for the multiplication path: the BCD converter states,
// default widths and a constant helper used to check digit capacity.
package conversor_bcd_resultado_pkg;

    localparam int ANCHO_BIN_DEF = 8;
    localparam int DIGITOS_DEF   = 3;
    localparam int BCD_DIGIT_W   = 4;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_bcd_t;

    // 10^n as a constant, used to check that DIGITOS can hold the largest product
    function automatic longint potencia10(input int n);
        longint acum;
        acum = 64'd1;
        for (int i = 0; i < n; i++) begin
            acum = acum * 64'd10;
        end
        return acum;
    endfunction

endpackage

// File: rtl/conversor_bcd_resultado_celda_suma3.sv
// One BCD digit correction cell of the double-dabble engine: a digit that
// would overflow past 9 after the next doubling is pre-corrected by +3.
module celda_suma3
    import conversor_bcd_resultado_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] entrada,
    output logic [BCD_DIGIT_W-1:0] salida
);

    // Add 3 when the digit is 5 or more, otherwise pass it through
    always_comb begin
        salida = entrada;
        if (entrada >= 4'd5) begin
            salida = entrada + 4'd3;
        end else begin
            salida = entrada;
        end
    end

endmodule

// File: rtl/conversor_bcd_resultado.sv
// Converts the unsigned product from the multiplier into packed BCD digits
// with a sequential shift-and-add-3 engine, one bit per clock. Results are
// held for the seven-segment driver and announced with a one-cycle pulse.
module conversor_bcd_resultado
    import conversor_bcd_resultado_pkg::*;
#(
    parameter int ANCHO_BIN = ANCHO_BIN_DEF,
    parameter int DIGITOS   = DIGITOS_DEF
) (
    input  logic                         reloj,
    input  logic                         reinicio,
    input  logic [ANCHO_BIN-1:0]         resultado,
    input  logic                         banderaLista,
    output logic                         ocupado,
    output logic [BCD_DIGIT_W*DIGITOS-1:0] bcd,
    output logic                         banderaBcdValida
);

    localparam int BCD_W  = BCD_DIGIT_W * DIGITOS;
    localparam int REG_W  = BCD_W + ANCHO_BIN;
    localparam int CONT_W = $clog2(ANCHO_BIN) + 1;
    localparam logic [CONT_W-1:0] ULTIMA_ITER = CONT_W'(ANCHO_BIN - 1);
    localparam bit DIGITOS_OK =
        potencia10(DIGITOS) > ((longint'(1) << ANCHO_BIN) - longint'(1));

    // The digit count must be able to represent the largest binary input
    if (!DIGITOS_OK) begin : g_error_digitos
        $error("DIGITOS too small for ANCHO_BIN");
    end

    estado_bcd_t          estado_q, estado_d;
    logic [REG_W-1:0]     desplaza_q, desplaza_d;
    logic [CONT_W-1:0]    contador_q, contador_d;
    logic                 bandera_prev_q;
    logic [ANCHO_BIN-1:0] ultimo_valor_q, ultimo_valor_d;
    logic [BCD_W-1:0]     bcd_q, bcd_d;
    logic                 valida_q, valida_d;
    logic                 ocupado_q, ocupado_d;
    logic [REG_W-1:0]     corregido_s;
    logic                 captura_s;

    // The binary field is never corrected; only the BCD digits pass through cells
    assign corregido_s[ANCHO_BIN-1:0] = desplaza_q[ANCHO_BIN-1:0];

    for (genvar i = 0; i < DIGITOS; i++) begin : g_celdas
        celda_suma3 u_celda (
            .entrada (desplaza_q[ANCHO_BIN + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .salida  (corregido_s[ANCHO_BIN + BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    // A new conversion starts on a rising flag, or on a changed product while the
    // flag stays high; a held flag with the same product is converted only once.
    assign captura_s = banderaLista &&
                       (!bandera_prev_q || (resultado != ultimo_valor_q));

    // Next-state and datapath update for the conversion sequencer
    always_comb begin
        estado_d       = estado_q;
        desplaza_d     = desplaza_q;
        contador_d     = contador_q;
        ultimo_valor_d = ultimo_valor_q;
        bcd_d          = bcd_q;
        valida_d       = 1'b0;
        case (estado_q)
            INACTIVO: begin
                if (captura_s) begin
                    desplaza_d     = {{BCD_W{1'b0}}, resultado};
                    ultimo_valor_d = resultado;
                    contador_d     = {CONT_W{1'b0}};
                    estado_d       = DESPLAZA;
                end else begin
                    estado_d       = INACTIVO;
                end
            end
            DESPLAZA: begin
                desplaza_d = {corregido_s[REG_W-2:0], 1'b0};
                contador_d = contador_q + CONT_W'(1);
                if (contador_q == ULTIMA_ITER) begin
                    estado_d = FIN;
                end else begin
                    estado_d = DESPLAZA;
                end
            end
            FIN: begin
                bcd_d    = desplaza_q[REG_W-1:ANCHO_BIN];
                valida_d = 1'b1;
                estado_d = INACTIVO;
            end
            default: begin
                estado_d = INACTIVO;
            end
        endcase
        ocupado_d = (estado_d != INACTIVO);
    end

    // State and output registers; reset aborts any conversion without a pulse
    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estado_q       <= INACTIVO;
            desplaza_q     <= {REG_W{1'b0}};
            contador_q     <= {CONT_W{1'b0}};
            bandera_prev_q <= 1'b0;
            ultimo_valor_q <= {ANCHO_BIN{1'b0}};
            bcd_q          <= {BCD_W{1'b0}};
            valida_q       <= 1'b0;
            ocupado_q      <= 1'b0;
        end else begin
            estado_q       <= estado_d;
            desplaza_q     <= desplaza_d;
            contador_q     <= contador_d;
            bandera_prev_q <= banderaLista;
            ultimo_valor_q <= ultimo_valor_d;
            bcd_q          <= bcd_d;
            valida_q       <= valida_d;
            ocupado_q      <= ocupado_d;
        end
    end

    assign ocupado          = ocupado_q;
    assign bcd              = bcd_q;
    assign banderaBcdValida = valida_q;

endmodule
